// File: rtl/i2c_receptor.sv
// I2C target: resolves open-drain SDA, decodes START/STOP, ACKs SLV_ADDR, moves one 16-bit word per transfer (high byte first).
// Target SDA drive updates 1 clk after an SCL fall is seen; no backpressure, the generator owns all bus timing.
module i2c_receptor #(
  parameter logic [6:0] SLV_ADDR = 7'h2A,
  parameter int         DATA_W   = 16
) (
  input  logic              clk,
  input  logic              RESET,
  input  logic              SCL,
  input  logic              SDA_OUT,
  input  logic              SDA_OE,
  output logic              SDA_IN,
  input  logic [DATA_W-1:0] TX_DATA,
  output logic [DATA_W-1:0] RX_DATA,
  output logic              RX_VALID,
  output logic              BUSY,
  output logic              ADDR_HIT
);

  typedef enum logic [2:0] {
    IDLE, ADDR, ADDR_ACK, WR_BYTE, WR_ACK, RD_BYTE, RD_ACK, IGNORE
  } state_t;

  state_t            state, state_nxt;
  logic              slv_low, slv_low_nxt;
  logic              scl_q, sda_q;
  logic [2:0]        bit_cnt, bit_cnt_nxt;
  logic              full, full_nxt;
  logic [1:0]        byte_idx, byte_idx_nxt;
  logic [7:0]        shift, shift_nxt;
  logic              rnw, rnw_nxt;
  logic [15:0]       tx_sh, tx_sh_nxt;
  logic [7:0]        hi_byte, hi_nxt;
  logic [DATA_W-1:0] rx_data, rx_data_nxt;
  logic              rx_valid, rx_valid_nxt;
  logic              busy, busy_nxt;
  logic              addr_hit, hit_nxt;

  logic sda, rise, fall, start_c, stop_c, tx_bit;

  assign sda     = (SDA_OE ? SDA_OUT : 1'b1) & ~slv_low;
  assign rise    = SCL & ~scl_q;
  assign fall    = ~SCL & scl_q;
  assign start_c = scl_q & SCL & sda_q & ~sda;
  assign stop_c  = scl_q & SCL & ~sda_q & sda;
  // Bit k of byte 0 is tx_sh[15-k], of byte 1 tx_sh[7-k]; bit_cnt holds k after k rises.
  assign tx_bit  = tx_sh[{~byte_idx[0], ~bit_cnt}];

  always_comb begin
    state_nxt    = state;
    slv_low_nxt  = slv_low;
    bit_cnt_nxt  = bit_cnt;
    full_nxt     = full;
    byte_idx_nxt = byte_idx;
    shift_nxt    = shift;
    rnw_nxt      = rnw;
    tx_sh_nxt    = tx_sh;
    hi_nxt       = hi_byte;
    rx_data_nxt  = rx_data;
    rx_valid_nxt = 1'b0;
    busy_nxt     = busy;
    hit_nxt      = addr_hit;
    if (stop_c) begin
      state_nxt   = IDLE;
      slv_low_nxt = 1'b0;
      busy_nxt    = 1'b0;
      hit_nxt     = 1'b0;
    end else if (start_c) begin
      state_nxt    = ADDR;
      bit_cnt_nxt  = 3'd0;
      full_nxt     = 1'b0;
      byte_idx_nxt = 2'd0;
      slv_low_nxt  = 1'b0;
      busy_nxt     = 1'b1;
      hit_nxt      = 1'b0;
    end else begin
      // full marks the 8th rise so the following fall can close the byte.
      if (rise && (state == ADDR || state == WR_BYTE || state == RD_BYTE)) begin
        shift_nxt = {shift[6:0], sda};
        if (bit_cnt == 3'd7) full_nxt = 1'b1;
        else                 bit_cnt_nxt = bit_cnt + 3'd1;
      end
      case (state)
        ADDR: begin
          if (fall && full) begin
            full_nxt    = 1'b0;
            bit_cnt_nxt = 3'd0;
            if (shift[7:1] == SLV_ADDR) begin
              state_nxt   = ADDR_ACK;
              slv_low_nxt = 1'b1;
              rnw_nxt     = shift[0];
              hit_nxt     = 1'b1;
            end else begin
              state_nxt   = IGNORE;
              slv_low_nxt = 1'b0;
            end
          end
        end
        ADDR_ACK: begin
          if (fall) begin
            if (!rnw) begin
              state_nxt   = WR_BYTE;
              slv_low_nxt = 1'b0;
            end else begin
              state_nxt   = RD_BYTE;
              tx_sh_nxt   = TX_DATA[15:0];
              slv_low_nxt = ~TX_DATA[15];
            end
          end
        end
        WR_BYTE: begin
          if (fall && full) begin
            full_nxt    = 1'b0;
            bit_cnt_nxt = 3'd0;
            if (byte_idx < 2'd2) begin
              state_nxt   = WR_ACK;
              slv_low_nxt = 1'b1;
            end else begin
              state_nxt   = IGNORE;
              slv_low_nxt = 1'b0;
            end
          end
        end
        WR_ACK: begin
          if (fall) begin
            state_nxt    = WR_BYTE;
            slv_low_nxt  = 1'b0;
            byte_idx_nxt = byte_idx + 2'd1;
            if (byte_idx == 2'd0) begin
              hi_nxt = shift;
            end else if (byte_idx == 2'd1) begin
              rx_data_nxt  = {hi_byte, shift};
              rx_valid_nxt = 1'b1;
            end
          end
        end
        RD_BYTE: begin
          if (fall) begin
            if (full) begin
              state_nxt   = RD_ACK;
              full_nxt    = 1'b0;
              bit_cnt_nxt = 3'd0;
              slv_low_nxt = 1'b0;
            end else begin
              slv_low_nxt = ~tx_bit;
            end
          end
        end
        RD_ACK: begin
          if (rise) begin
            if (!sda && byte_idx == 2'd0) begin
              byte_idx_nxt = 2'd1;
              full_nxt     = 1'b1;
            end else begin
              state_nxt = IGNORE;
            end
          end else if (fall && full) begin
            state_nxt   = RD_BYTE;
            full_nxt    = 1'b0;
            bit_cnt_nxt = 3'd0;
            slv_low_nxt = ~tx_sh[7];
          end
        end
        IDLE, IGNORE: ;
        default: state_nxt = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge RESET) begin
    if (!RESET) begin
      state    <= IDLE;
      slv_low  <= 1'b0;
      scl_q    <= 1'b1;
      sda_q    <= 1'b1;
      bit_cnt  <= 3'd0;
      full     <= 1'b0;
      byte_idx <= 2'd0;
      shift    <= 8'd0;
      rnw      <= 1'b0;
      tx_sh    <= 16'd0;
      hi_byte  <= 8'd0;
      rx_data  <= '0;
      rx_valid <= 1'b0;
      busy     <= 1'b0;
      addr_hit <= 1'b0;
    end else begin
      state    <= state_nxt;
      slv_low  <= slv_low_nxt;
      scl_q    <= SCL;
      sda_q    <= sda;
      bit_cnt  <= bit_cnt_nxt;
      full     <= full_nxt;
      byte_idx <= byte_idx_nxt;
      shift    <= shift_nxt;
      rnw      <= rnw_nxt;
      tx_sh    <= tx_sh_nxt;
      hi_byte  <= hi_nxt;
      rx_data  <= rx_data_nxt;
      rx_valid <= rx_valid_nxt;
      busy     <= busy_nxt;
      addr_hit <= hit_nxt;
    end
  end

  assign SDA_IN   = sda;
  assign RX_DATA  = rx_data;
  assign RX_VALID = rx_valid;
  assign BUSY     = busy;
  assign ADDR_HIT = addr_hit;

endmodule

// File: tb/tb_i2c_receptor.sv
// Bench for i2c_receptor: bit-banged I2C master plus a transaction-level expectation model,
// checked every clk by one compare process, with directed and randomized transfers.
`timescale 1ns/1ps
module tb_i2c_receptor;
  localparam logic [6:0] ADDR = 7'h2A;

  logic        clk = 1'b0;
  logic        RESET, SCL, SDA_OUT, SDA_OE, SDA_IN, RX_VALID, BUSY, ADDR_HIT;
  logic [15:0] TX_DATA, RX_DATA;

  i2c_receptor #(.SLV_ADDR(ADDR), .DATA_W(16)) dut (
    .clk(clk), .RESET(RESET), .SCL(SCL), .SDA_OUT(SDA_OUT), .SDA_OE(SDA_OE),
    .SDA_IN(SDA_IN), .TX_DATA(TX_DATA), .RX_DATA(RX_DATA), .RX_VALID(RX_VALID),
    .BUSY(BUSY), .ADDR_HIT(ADDR_HIT)
  );

  always #5 clk = ~clk;

  int tests = 0;
  int fails = 0;
  int hp = 3;
  int vld_cnt = 0;

  // Expected DUT state, updated at the negedge of the bus action that causes the change.
  logic        exp_busy = 1'b0, exp_hit = 1'b0, exp_vld = 1'b0;
  logic        exp_sda = 1'b1, exp_sda_vld = 1'b0;
  logic [15:0] exp_rx = 16'h0;
  logic [7:0]  wr_hi = 8'h0;

  task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  always @(posedge clk) begin
    #2;
    check("BUSY", 16'(BUSY), 16'(exp_busy));
    check("ADDR_HIT", 16'(ADDR_HIT), 16'(exp_hit));
    check("RX_DATA", RX_DATA, exp_rx);
    check("RX_VALID", 16'(RX_VALID), 16'(exp_vld));
    if (exp_sda_vld) check("SDA_IN", 16'(SDA_IN), 16'(exp_sda));
    if (RX_VALID === 1'b1) vld_cnt++;
  end

  task automatic tick(input int n);
    repeat (n) begin
      @(negedge clk);
      exp_vld = 1'b0;
    end
  endtask

  // One SCL bit cycle; returns at the negedge where SCL has just been driven low.
  task automatic do_bit(input logic drive, input logic val, input logic line, output logic got);
    tick(1);
    SDA_OE  = drive;
    SDA_OUT = drive ? val : 1'b1;
    tick(hp);
    SCL = 1'b1; exp_sda = line; exp_sda_vld = 1'b1;
    tick(hp);
    got = SDA_IN; exp_sda_vld = 1'b0;
    SCL = 1'b0;
  endtask

  task automatic start_cond();
    tick(1);
    SDA_OE = 1'b1; SDA_OUT = 1'b1; exp_sda_vld = 1'b0;
    tick(hp);
    SCL = 1'b1;
    tick(hp);
    SDA_OUT = 1'b0; exp_busy = 1'b1; exp_hit = 1'b0;
    tick(hp);
    SCL = 1'b0;
  endtask

  task automatic stop_cond();
    tick(1);
    SDA_OE = 1'b1; SDA_OUT = 1'b0; exp_sda_vld = 1'b0;
    tick(hp);
    SCL = 1'b1;
    tick(hp);
    SDA_OUT = 1'b1; exp_busy = 1'b0; exp_hit = 1'b0;
    tick(hp);
    SDA_OE = 1'b0;
    tick(hp);
  endtask

  task automatic send_addr(input logic [7:0] a, output logic hit);
    logic g;
    hit = (a[7:1] == ADDR);
    for (int i = 7; i >= 0; i--) do_bit(1'b1, a[i], a[i], g);
    if (hit) exp_hit = 1'b1;
    do_bit(1'b0, 1'b1, ~hit, g);
  endtask

  task automatic wr_byte(input logic [7:0] b, input int idx, input logic hit);
    logic g, ack;
    for (int i = 7; i >= 0; i--) do_bit(1'b1, b[i], b[i], g);
    ack = hit && (idx < 2);
    do_bit(1'b0, 1'b1, ~ack, g);
    if (hit && idx == 0) wr_hi = b;
    if (hit && idx == 1) begin
      exp_rx  = {wr_hi, b};
      exp_vld = 1'b1;
    end
  endtask

  task automatic rd_byte(input logic [7:0] expb, input logic mack, output logic [7:0] got);
    logic g;
    for (int i = 7; i >= 0; i--) begin
      do_bit(1'b0, 1'b1, expb[i], g);
      got[i] = g;
    end
    do_bit(mack, 1'b0, ~mack, g);
  endtask

  task automatic write_txn(input logic [6:0] a, input logic [23:0] bytes, input int n);
    logic hit;
    start_cond();
    send_addr({a, 1'b0}, hit);
    for (int k = 0; k < n; k++) wr_byte(bytes[23-8*k -: 8], k, hit);
    stop_cond();
  endtask

  // Address + read phase; TX_DATA is scrambled right after the latch point.
  task automatic read_body(input logic [15:0] w, input int nb, output logic [15:0] got);
    logic hit;
    logic [7:0] b0, b1;
    b1 = 8'h0;
    TX_DATA = w;
    send_addr({ADDR, 1'b1}, hit);
    tick(1);
    TX_DATA = 16'($urandom);
    rd_byte(w[15:8], nb == 2, b0);
    if (nb == 2) rd_byte(w[7:0], 1'b0, b1);
    got = {b0, b1};
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [15:0] g16, w;
    logic [6:0]  a;
    logic        hit, g;
    int          v0, kind, n;

    RESET = 1'b0; SCL = 1'b1; SDA_OE = 1'b0; SDA_OUT = 1'b1; TX_DATA = 16'h0;
    tick(3);
    check("rst_RX_DATA", RX_DATA, 16'h0000);
    check("rst_BUSY", 16'(BUSY), 16'h0);
    check("rst_SDA_IN", 16'(SDA_IN), 16'h1);
    RESET = 1'b1;
    tick(3);

    // Write 0xBEEF
    write_txn(7'h2A, 24'hBEEF00, 2);
    check("wr_RX_DATA", RX_DATA, 16'hBEEF);
    check("wr_vld_cnt", 16'(vld_cnt), 16'd1);
    check("wr_BUSY_after_stop", 16'(BUSY), 16'h0);

    // Read 0xA55A
    start_cond();
    read_body(16'hA55A, 2, g16);
    check("rd_hit_before_stop", 16'(ADDR_HIT), 16'h1);
    stop_cond();
    check("rd_word", g16, 16'hA55A);
    check("rd_hit_after_stop", 16'(ADDR_HIT), 16'h0);

    // Address miss
    v0 = vld_cnt;
    start_cond();
    send_addr(8'h40, hit);
    check("miss_ADDR_HIT", 16'(ADDR_HIT), 16'h0);
    wr_byte(8'hFF, 0, hit);
    stop_cond();
    check("miss_vld_cnt", 16'(vld_cnt), 16'(v0));
    check("miss_BUSY", 16'(BUSY), 16'h0);

    // Abort after 4 bits of the second byte
    start_cond();
    send_addr({ADDR, 1'b0}, hit);
    wr_byte(8'h12, 0, hit);
    for (int i = 0; i < 4; i++) do_bit(1'b1, 1'b1, 1'b1, g);
    stop_cond();
    check("abort_RX_DATA", RX_DATA, 16'hBEEF);
    check("abort_vld_cnt", 16'(vld_cnt), 16'(v0));

    // Repeated START: one write byte, then a read
    start_cond();
    send_addr({ADDR, 1'b0}, hit);
    wr_byte(8'h11, 0, hit);
    start_cond();
    read_body(16'h3C96, 2, g16);
    stop_cond();
    check("rs_word", g16, 16'h3C96);
    check("rs_vld_cnt", 16'(vld_cnt), 16'(v0));

    // Reset while the target drives a 0 data bit
    TX_DATA = 16'h0F0F;
    start_cond();
    send_addr({ADDR, 1'b1}, hit);
    tick(2);
    check("rstmid_drive_low", 16'(SDA_IN), 16'h0);
    RESET = 1'b0;
    exp_busy = 1'b0; exp_hit = 1'b0; exp_rx = 16'h0; exp_vld = 1'b0;
    #1;
    check("rstmid_SDA_IN", 16'(SDA_IN), 16'h1);
    check("rstmid_BUSY", 16'(BUSY), 16'h0);
    check("rstmid_RX_DATA", RX_DATA, 16'h0000);
    tick(1);
    SCL = 1'b1;
    tick(3);
    RESET = 1'b1;
    tick(3);
    write_txn(ADDR, 24'h123400, 2);
    check("rstmid_next_wr", RX_DATA, 16'h1234);

    // Randomized transfers
    for (int it = 0; it < 40; it++) begin
      hp   = $urandom_range(2, 5);
      kind = $urandom_range(0, 4);
      w    = 16'($urandom);
      case (kind)
        0: begin
          n = $urandom_range(2, 3);
          write_txn(ADDR, {w, 8'($urandom)}, n);
          check("rnd_wr_word", RX_DATA, w);
        end
        1: begin
          a = 7'($urandom);
          if (a == ADDR) a = a ^ 7'h01;
          v0 = vld_cnt;
          write_txn(a, {w, 8'($urandom)}, $urandom_range(1, 3));
          check("rnd_miss_vld", 16'(vld_cnt), 16'(v0));
        end
        2: begin
          start_cond();
          read_body(w, 2, g16);
          stop_cond();
          check("rnd_rd_word", g16, w);
        end
        3: begin
          start_cond();
          read_body(w, 1, g16);
          stop_cond();
          check("rnd_rd_byte", {8'h00, g16[15:8]}, {8'h00, w[15:8]});
        end
        default: begin
          v0 = vld_cnt;
          write_txn(ADDR, {w, 8'h00}, 1);
          check("rnd_partial_vld", 16'(vld_cnt), 16'(v0));
        end
      endcase
      tick($urandom_range(1, 6));
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/i2c_receptor.md
Name: i2c_receptor

Overview:
I2C target (slave) stage on the bus driven by the I2C generator. It consumes the generator's SCL/SDA_OUT/SDA_OE, resolves the open-drain SDA line, and returns the resolved line as SDA_IN. It decodes START/STOP, matches a 7-bit address and ACKs it. On a write it accepts two data bytes into RX_DATA. On a read it returns TX_DATA as two bytes. Word order is high byte first in both directions.

Parameters:
SLV_ADDR, 7'h2A, 7-bit target address this block answers to
DATA_W, 16, data word width; fixed at 2 bytes (only 16 supported)

Ports:
clk  input  1  system clock; SCL/SDA_OUT/SDA_OE are synchronous to it
RESET  input  1  asynchronous, active-low reset
SCL  input  1  bus clock from generator
SDA_OUT  input  1  generator SDA drive value
SDA_OE  input  1  generator SDA output enable (1 = generator drives)
SDA_IN  output  1  resolved SDA line, fed back to generator
TX_DATA  input  16  word returned on read; latched at read-phase start
RX_DATA  output  16  last complete word received on write
RX_VALID  output  1  one-clk pulse when RX_DATA updates
BUSY  output  1  high between START and STOP
ADDR_HIT  output  1  high from address ACK until STOP/START

Behaviour:
- Line resolution is a combinational wired-AND: sda = (SDA_OE ? SDA_OUT : 1) & ~slv_low, where slv_low is a registered internal drive. SDA_IN = sda.
- One register stage each for SCL and sda: scl_q, sda_q.
  - rise = SCL & ~scl_q; fall = ~SCL & scl_q.
  - START = scl_q & SCL & sda_q & ~sda.
  - STOP = scl_q & SCL & ~sda_q & sda.
- Data is sampled on rise. slv_low changes on the clk after fall is detected (1-clk latency). SCL high/low must each last >= 2 clk.
- Reset (RESET=0, async): state=IDLE, slv_low=0, RX_DATA=0, RX_VALID=0, BUSY=0, ADDR_HIT=0, bit_cnt=0, byte_idx=0. SDA_IN follows the line (1 if SDA_OE=0). Reset mid-transfer releases SDA at once.
- STOP in any state: go to IDLE, slv_low=0, BUSY=0, ADDR_HIT=0. RX_DATA is not updated by a partial word.
- START in any state, including repeated START: go to ADDR, bit_cnt=0, byte_idx=0, slv_low=0, BUSY=1, ADDR_HIT=0.
- States:
  - IDLE: wait for START.
  - ADDR: shift sda MSB-first on each rise, 8 bits. On the fall after the 8th rise:
    - shift[7:1]==SLV_ADDR: slv_low=1, go to ADDR_ACK, latch rnw=shift[0].
    - otherwise: go to IGNORE, SDA released.
  - ADDR_ACK: hold low through the 9th rise. ADDR_HIT=1. On the next fall:
    - rnw=0: slv_low=0, go to WR_BYTE.
    - rnw=1: latch TX_DATA into tx_sh, drive bit15 (slv_low = ~tx_sh[15]), go to RD_BYTE.
  - WR_BYTE: shift 8 bits on rise. On the fall after the 8th:
    - byte_idx<2: slv_low=1 (ACK), go to WR_ACK.
    - byte_idx==2 (third byte): slv_low=0 (NACK), go to IGNORE.
  - WR_ACK: on the next fall, slv_low=0, byte_idx+1.
    - After byte 0: store high byte.
    - After byte 1: RX_DATA<={hi,lo}; RX_VALID=1 for exactly one clk.
    - Return to WR_BYTE.
  - RD_BYTE: on each fall shift out the next bit. slv_low = ~bit (a 1 is released, never driven high). On the fall after the 8th bit, slv_low=0, go to RD_ACK.
  - RD_ACK: sample sda on the 9th rise.
    - sda=0 (master ACK) and byte_idx==0: byte_idx=1, drive bit7 of tx_sh on the next fall, go to RD_BYTE.
    - NACK, or byte_idx==1: go to IGNORE.
  - IGNORE: SDA released; wait for STOP or START.
- TX_DATA changes after latch do not affect the current read.
- bit_cnt is 3 bits, wraps 7→0 only via state transition, never free-running.

Test Plan:
- Write: START, addr 0x54 (0x2A,W), bytes 0xBE 0xEF, STOP -> SDA_IN low on all 3 ACK bits; RX_DATA=16'hBEEF; RX_VALID one clk high; BUSY low after STOP.
- Read: TX_DATA=16'hA55A; START, 0x55, master ACK then NACK, STOP -> SDA_IN bits A5 then 5A MSB-first; slave ACK at address bit 9; ADDR_HIT high until STOP.
- Address miss: START, 0x40 -> SDA_IN stays 1 at bit 9; state IGNORE; RX_VALID never pulses; BUSY drops at STOP.
- Abort: write 0x12 then STOP after 4 bits of second byte -> RX_DATA keeps its previous value; no RX_VALID.
- Repeated START: write 1 byte, START, read 2 bytes -> read returns TX_DATA correctly; no RX_VALID.
- Reset mid-read while slave drives low -> SDA_IN returns to 1 immediately; all outputs reach their reset values; next transaction succeeds.
